// File: rtl/wall_probe_server.sv
`default_nettype none
// ============================================================================
//  Module      : wall_probe_server
//  Description : Sequential collision-probe responder. Takes one sprite
//                position + move direction, reads the wall rows it needs over
//                a single synchronous-read row port (one row per cycle), and
//                returns one blocked/clear answer. Anything outside the map
//                counts as wall.
//  Revision    : 1.0 - initial release
// ============================================================================
module wall_probe_server #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int SIZE = 16,
    parameter int AW   = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_dir,
    input  logic [AW-1:0]   req_x,
    input  logic [AW-1:0]   req_y,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_blocked,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [COLS-1:0] mem_data
);

    localparam int SW = $clog2(SIZE + 1);

    // All geometry is done one bit wider than a coordinate so x-1 / y-1 at 0
    // and x+SIZE near the edge land above the map limits instead of wrapping.
    localparam logic [AW:0] c_one    = (AW+1)'(1);
    localparam logic [AW:0] c_size_w = (AW+1)'(SIZE);
    localparam logic [AW:0] c_rows_w = (AW+1)'(ROWS);
    localparam logic [AW:0] c_cols_w = (AW+1)'(COLS);
    localparam logic [SW-1:0] c_last_h = SW'(SIZE - 1);

    localparam logic [COLS-1:0] c_bit_mask  = {{(COLS-1){1'b0}}, 1'b1};
    localparam logic [COLS-1:0] c_span_mask = {{(COLS-SIZE){1'b0}}, {SIZE{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q,        state_d;
    logic [1:0]      dir_q,          dir_d;
    logic [AW-1:0]   x_q,            x_d;
    logic [AW-1:0]   y_q,            y_d;
    logic [SW-1:0]   slot_q,         slot_d;
    logic            acc_q,          acc_d;
    logic            rd_pend_q,      rd_pend_d;
    logic            req_ready_q,    req_ready_d;
    logic            resp_valid_q,   resp_valid_d;
    logic            resp_blocked_q, resp_blocked_d;
    logic            mem_rd_q,       mem_rd_d;
    logic [AW-1:0]   mem_addr_q,     mem_addr_d;

    // Geometry of the slot being issued: from the request ports on the
    // accepting edge, from the latched probe for every later slot.
    logic [1:0]      w_dir_s;
    logic [AW-1:0]   w_x_s;
    logic [AW-1:0]   w_y_s;
    logic [SW-1:0]   w_k_s;
    logic [AW:0]     w_row;
    logic [AW:0]     w_col_h;
    logic [AW:0]     w_x_end;
    logic            w_oob;
    logic [SW-1:0]   w_last;

    // Row-data fold for the read issued in the previous cycle.
    logic [AW:0]     w_col_f;
    logic [COLS-1:0] w_mask;
    logic            w_fold;

    // Select slot operands and compute its row, column and out-of-map flag
    always_comb begin
        if (state_q == S_IDLE) begin
            w_dir_s = req_dir;
            w_x_s   = req_x;
            w_y_s   = req_y;
            w_k_s   = '0;
        end else begin
            w_dir_s = dir_q;
            w_x_s   = x_q;
            w_y_s   = y_q;
            w_k_s   = SW'(slot_q + 1'b1);
        end
        case (w_dir_s)
            2'd0:    w_row = {1'b0, w_y_s} - c_one;
            2'd1:    w_row = {1'b0, w_y_s} + c_size_w;
            default: w_row = {1'b0, w_y_s} + (AW+1)'(w_k_s);
        endcase
        w_col_h = w_dir_s[0] ? ({1'b0, w_x_s} + c_size_w) : ({1'b0, w_x_s} - c_one);
        w_x_end = {1'b0, w_x_s} + c_size_w - c_one;
        w_oob   = (w_row >= c_rows_w) ||
                  (w_dir_s[1] ? (w_col_h >= c_cols_w) : (w_x_end >= c_cols_w));
        w_last  = dir_q[1] ? c_last_h : '0;
    end

    // Mask the returned row down to the probed column (horizontal) or span
    always_comb begin
        w_col_f = dir_q[0] ? ({1'b0, x_q} + c_size_w) : ({1'b0, x_q} - c_one);
        w_mask  = dir_q[1] ? (c_bit_mask << w_col_f) : (c_span_mask << x_q);
        w_fold  = rd_pend_q & (|(mem_data & w_mask));
    end

    // Next-state logic for the probe sequencer and its registered outputs
    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        x_d            = x_q;
        y_d            = y_q;
        slot_d         = slot_q;
        acc_d          = acc_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_blocked_d = resp_blocked_q;
        mem_rd_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        rd_pend_d      = mem_rd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d     = S_ISSUE;
                    dir_d       = req_dir;
                    x_d         = req_x;
                    y_d         = req_y;
                    slot_d      = '0;
                    req_ready_d = 1'b0;
                    acc_d       = w_oob;
                    mem_rd_d    = ~w_oob;
                    if (!w_oob) mem_addr_d = w_row[AW-1:0];
                end
            end
            S_ISSUE: begin
                acc_d = acc_q | w_fold;
                if (slot_q == w_last) begin
                    state_d = S_DRAIN;
                end else begin
                    slot_d   = w_k_s;
                    acc_d    = acc_q | w_fold | w_oob;
                    mem_rd_d = ~w_oob;
                    if (!w_oob) mem_addr_d = w_row[AW-1:0];
                end
            end
            S_DRAIN: begin
                acc_d          = acc_q | w_fold;
                resp_blocked_d = acc_q | w_fold;
                resp_valid_d   = 1'b1;
                state_d        = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            dir_q          <= 2'd0;
            x_q            <= '0;
            y_q            <= '0;
            slot_q         <= '0;
            acc_q          <= 1'b0;
            rd_pend_q      <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_blocked_q <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            x_q            <= x_d;
            y_q            <= y_d;
            slot_q         <= slot_d;
            acc_q          <= acc_d;
            rd_pend_q      <= rd_pend_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_blocked_q <= resp_blocked_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_blocked = resp_blocked_q;
    assign mem_rd       = mem_rd_q;
    assign mem_addr     = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_probe_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wall_probe_server
//  Description : Self-checking bench for wall_probe_server. Table of directed
//                probes with hand-computed answers and latencies, plus
//                backpressure and mid-probe reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wall_probe_server;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int SIZE = 16;
    localparam int AW   = 10;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_dir;
    logic [AW-1:0]   req_x;
    logic [AW-1:0]   req_y;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_blocked;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [COLS-1:0] mem_data;

    wall_probe_server #(.COLS(COLS), .ROWS(ROWS), .SIZE(SIZE), .AW(AW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dir      (req_dir),
        .req_x        (req_x),
        .req_y        (req_y),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_blocked (resp_blocked),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read wall memory: data valid the cycle after the strobe.
    logic [COLS-1:0] wall_map [ROWS];
    always @(posedge Clk) begin
        if (mem_rd) begin
            if (mem_addr < AW'(ROWS)) mem_data <= wall_map[mem_addr];
            else                      mem_data <= '1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] dir;
        int x;
        int y;
        bit wall;
        int wr;
        int wc;
        bit blk;
        int lat;
        int reads;
        int first;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic set_wall(input int r, input int c, input logic v);
        logic [COLS-1:0] row;
        row = wall_map[r];
        row[c] = v;
        wall_map[r] = row;
    endtask

    task automatic start_probe(input logic [1:0] d, input int x, input int y);
        @(negedge Clk);
        check("req_ready_before_accept", req_ready, 1);
        req_dir   = d;
        req_x     = AW'(x);
        req_y     = AW'(y);
        req_valid = 1'b1;
        @(posedge Clk);
        #1 req_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts edges until resp_valid.
    task automatic wait_resp(input int first, output int lat, output int reads,
                             output int bad_addr);
        bit done;
        done = 0; lat = 0; reads = 0; bad_addr = 0;
        while (!done && lat < 40) begin
            @(negedge Clk);
            if (resp_valid) done = 1;
            else begin
                if (mem_rd) begin
                    if (int'(mem_addr) != first + reads) bad_addr++;
                    reads++;
                end
                @(posedge Clk);
                lat++;
            end
        end
    endtask

    task automatic transfer();
        resp_ready = 1'b1;
        @(posedge Clk);
        #1 resp_ready = 1'b0;
        check("resp_valid_after_xfer", resp_valid, 0);
        check("req_ready_after_xfer", req_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, reads, bad;
        if (v.wall) set_wall(v.wr, v.wc, 1'b1);
        start_probe(v.dir, v.x, v.y);
        wait_resp(v.first, lat, reads, bad);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_reads", idx), reads, v.reads);
        check($sformatf("v%0d_addr_order", idx), bad, 0);
        check($sformatf("v%0d_blocked", idx), resp_blocked, v.blk);
        transfer();
        if (v.wall) set_wall(v.wr, v.wc, 1'b0);
    endtask

    initial begin
        int lat, reads, bad;
        for (int r = 0; r < ROWS; r++) wall_map[r] = '0;
        mem_data   = '0;
        Reset      = 1'b1;
        req_valid  = 1'b0;
        req_dir    = 2'd0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b0;

        //          dir    x    y   wall row  col blk lat rd first
        vecs[0]  = '{2'd3, 100, 200, 0,   0,   0, 0, 17, 16, 200};
        vecs[1]  = '{2'd3, 100, 200, 1, 215, 116, 1, 17, 16, 200};
        vecs[2]  = '{2'd3, 100, 200, 1, 215, 117, 0, 17, 16, 200};
        vecs[3]  = '{2'd2,   0,  50, 0,   0,   0, 1, 17,  0,   0};
        vecs[4]  = '{2'd1, 300, 100, 1, 116, 316, 0,  2,  1, 116};
        vecs[5]  = '{2'd1, 300, 100, 1, 116, 315, 1,  2,  1, 116};
        vecs[6]  = '{2'd0, 300, 100, 1,  99, 300, 1,  2,  1,  99};
        vecs[7]  = '{2'd0,  10,   0, 0,   0,   0, 1,  2,  0,   0};
        vecs[8]  = '{2'd3, 624,  20, 0,   0,   0, 1, 17,  0,   0};
        vecs[9]  = '{2'd3, 623,   0, 0,   0,   0, 0, 17, 16,   0};
        vecs[10] = '{2'd2,  10, 464, 1, 479,   9, 1, 17, 16, 464};
        vecs[11] = '{2'd3, 100, 470, 0,   0,   0, 1, 17, 10, 470};
        vecs[12] = '{2'd1, 630, 100, 0,   0,   0, 1,  2,  0,   0};
        vecs[13] = '{2'd1, 100, 464, 0,   0,   0, 1,  2,  0,   0};
        vecs[14] = '{2'd2, 200, 300, 1, 300, 199, 1, 17, 16, 300};
        vecs[15] = '{2'd1, 300, 100, 1, 116, 299, 0,  2,  1, 116};

        repeat (3) @(posedge Clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_blocked", resp_blocked, 0);
        check("reset_mem_rd", mem_rd, 0);
        check("reset_mem_addr", int'(mem_addr), 0);
        @(negedge Clk) Reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Backpressure: hold the result 5 cycles while a second request waits.
        set_wall(215, 116, 1'b1);
        start_probe(2'd3, 100, 200);
        wait_resp(200, lat, reads, bad);
        check("bp_latency", lat, 17);
        set_wall(215, 116, 1'b0);
        req_dir   = 2'd1;
        req_x     = AW'(300);
        req_y     = AW'(100);
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("bp_resp_valid_hold", resp_valid, 1);
            check("bp_resp_blocked_hold", resp_blocked, 1);
            check("bp_req_ready_low", req_ready, 0);
            check("bp_no_read", mem_rd, 0);
        end
        transfer();
        @(posedge Clk);
        #1 req_valid = 1'b0;
        check("bp_second_accepted", req_ready, 0);
        wait_resp(116, lat, reads, bad);
        check("bp2_latency", lat, 2);
        check("bp2_reads", reads, 1);
        check("bp2_addr", bad, 0);
        check("bp2_blocked", resp_blocked, 0);
        transfer();

        // Reset during slot 7 of a right probe whose first row already hit a wall.
        set_wall(200, 116, 1'b1);
        start_probe(2'd3, 100, 200);
        repeat (7) @(posedge Clk);
        @(negedge Clk);
        check("rst_slot7_mem_rd", mem_rd, 1);
        check("rst_slot7_mem_addr", int'(mem_addr), 207);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_rd", mem_rd, 0);
        @(negedge Clk) Reset = 1'b0;
        set_wall(200, 116, 1'b0);
        start_probe(2'd3, 100, 200);
        wait_resp(200, lat, reads, bad);
        check("rst_fresh_latency", lat, 17);
        check("rst_fresh_reads", reads, 16);
        check("rst_fresh_addr", bad, 0);
        check("rst_fresh_blocked", resp_blocked, 0);
        transfer();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wall_probe_server.md
Name: wall_probe_server

Overview:
- Sequential responder for ball/sprite collision queries against the wall map.
- Accepts one probe request: a sprite position and a move direction. Reads the needed wall rows over a single synchronous-read row-memory port, one row per cycle. Returns a single blocked/clear answer.
- Replaces per-direction banks of parallel ROM instances with one time-multiplexed memory port shared by the motion controller.

Parameters:
- COLS, 640, wall-map width in pixels; also the width of one memory row.
- ROWS, 480, wall-map height in rows.
- SIZE, 16, sprite edge length in pixels; also the probe span.
- AW, 10, width of coordinates and of the memory row address.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  probe request present.
- req_ready  out  1  block can accept a request.
- req_dir  in  2  direction: 0 up, 1 down, 2 left, 3 right.
- req_x  in  AW  sprite top-left X.
- req_y  in  AW  sprite top-left Y.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_blocked  out  1  1 = move blocked; valid only while resp_valid is high.
- mem_rd  out  1  row read strobe.
- mem_addr  out  AW  row address.
- mem_data  in  COLS  row data; bit i is column i; 1 = wall. Valid the cycle after the mem_rd cycle.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_blocked=0, mem_rd=0, mem_addr=0, state IDLE, accumulator cleared.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - req_x, req_y and req_dir are latched on that edge.
  - The response transfers on an edge where resp_valid & resp_ready.
  - resp_valid and resp_blocked hold stable until that transfer.
- States:
  - IDLE: req_ready=1. Goes to ISSUE on acceptance.
  - ISSUE: req_ready=0. Runs N read slots, one per cycle.
  - DRAIN: one cycle to fold in the last returned row.
  - RESP: resp_valid=1. Goes to IDLE on transfer.
- Probe geometry (all index arithmetic at AW+1 bits, so there is no wrap):
  - Right: column c=x+SIZE, rows y..y+SIZE-1, N=SIZE.
  - Left: column c=x-1, rows y..y+SIZE-1, N=SIZE.
  - Down: row r=y+SIZE, columns x..x+SIZE-1, N=1.
  - Up: row r=y-1, columns x..x+SIZE-1, N=1.
- Result: resp_blocked is the OR over all probed bits.
- Out-of-map handling (anything outside the map counts as wall):
  - Left with x=0 forces blocked=1.
  - Right with c>=COLS forces blocked=1.
  - Up with y=0 forces blocked=1.
  - Any row >=ROWS forces blocked=1.
  - Vertical probes: columns >=COLS within x..x+SIZE-1 force blocked=1.
  - Out-of-map slots keep their cycle slot but drive mem_rd=0. Timing does not depend on the data.
- Timing:
  - Slot k (0..N-1) occupies the k+1-th cycle after the accepting edge: mem_rd=1 (unless out of map), mem_addr = the row for that slot.
  - Data for slot k is sampled on the following edge.
  - No early termination.
  - resp_valid rises on the (N+1)-th rising edge after the accepting edge: 17 edges for horizontal probes, 2 for vertical.
- Back-to-back requests: the earliest next acceptance is the edge after the response transfer. req_ready rises in the cycle after the transfer.
- mem_addr holds its last value when mem_rd=0. The value is don't-care there.
- Reset mid-operation: return to IDLE, discard the probe, drop resp_valid. Nothing is pending afterwards.
- A req_valid asserted while busy is ignored (not queued); the requester holds it until req_ready.

Test Plan:
- Right probe, x=100, y=200, wall map all zero -> mem_rd high 16 cycles, mem_addr 200..215 in order, resp_valid on edge 17, resp_blocked=0.
- Right probe, x=100, y=200, single wall bit at row 215, col 116 -> resp_blocked=1. Same bit at col 117 instead -> resp_blocked=0.
- Left probe, x=0, y=50 -> mem_rd never asserted, resp_valid still on edge 17, resp_blocked=1.
- Down probe, x=300, y=100, wall bit at row 116, col 316 -> blocked=0. Bit at col 315 -> blocked=1. One read at addr 116, resp_valid on edge 2.
- Backpressure: resp_ready held low 5 cycles -> resp_valid/resp_blocked stable; req_ready=0 until the transfer; a second request is accepted only after it.
- Reset asserted during slot 7 of a right probe -> next edge: IDLE, req_ready=1, resp_valid=0, mem_rd=0; a fresh probe completes with normal 17-edge latency.
